temp_display: RTL and testbench
===============================

# temp_display

Downstream consumer of the I2C temperature-read master's 16-bit result word (ADT7420 format, 13-bit two's complement in bits [15:3], LSB = 0.0625 °C). Detects a new reading and converts it to sign/hundreds/tens/units/tenths with a sequential double-dabble. Drives a 4-digit common-anode multiplexed 7-segment display. Switch `sw[0]` selects raw-hex display instead.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays enabled. Minimum 2.
- IDLE_WORD, 16'hFFFF: result-word value meaning "no reading yet". It is never converted.
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- raw  input  16  result word from the I2C master. Sampled every cycle; no valid strobe.
- sw  input  2  sw[0]: 0 = Celsius, 1 = hex. sw[1] is ignored.
- an  output  4  digit enables, active-low. an[3] is the leftmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- busy  output  1  high while a conversion is in flight.

## Operation
- Input register: `raw_q <= raw` and `mode_q <= sw[0]` every cycle.
- Shown register: `shown_raw` / `shown_mode` hold the last committed inputs. Reset value is IDLE_WORD / 0.
- FSM states:
  - IDLE. If `raw_q != IDLE_WORD` and (`raw_q != shown_raw` or `mode_q != shown_mode`), go to LATCH.
  - LATCH. Capture raw_q/mode_q. Compute `t = raw_q[15:3]` (signed 13-bit), `neg = t[12]`, `mag = |t|` (13-bit unsigned), `int = mag[12:4]` (9-bit), `tenths = (mag[3:0]*10) >> 4` (truncating). Hex mode goes to COMMIT; Celsius goes to SHIFT.
  - SHIFT. Runs 8 cycles of add-3/shift on `int[7:0]` into a 12-bit BCD, then goes to COMMIT. The counter is 3 bits, exit at 7.
  - COMMIT. Write the four digit codes and dp position, update shown_*, then go to IDLE.
- Celsius digit rules:
  - d1 = units with dp lit; d0 = tenths.
  - d2 = tens, blanked if hundreds = 0 and tens = 0.
  - d3 = '-' if neg; else hundreds, blanked if 0.
  - Out of range (`int > 255`, or neg with `int >= 100`): all four digits show '-' and dp is off.
- Hex digit rule: d3..d0 = raw nibbles [15:12]..[3:0], dp off.
- Input changes during LATCH/SHIFT/COMMIT are not aborted or queued. They are re-detected in IDLE against the new shown_raw.
- Digit code space (5-bit): 0–15 hex, BLANK, MINUS. Reset value of all digits is BLANK.
- Scan logic:
  - A 16-bit counter wraps at REFRESH_DIV-1 and then advances a 2-bit index 0→1→2→3→0.
  - Index k drives `an = ~(1<<k)`, `seg = pattern(d_k)`, `dp = ~(dp_en && k==1)`.
  - BLANK and MINUS patterns are 7'h7F and 7'h3F.

## Timing
- Reset (reset==0) state:
  - an=4'hF, seg=7'h7F, dp=1, busy=0.
  - FSM=IDLE, scan counter=0, index=0.
  - Digits BLANK, shown_raw=IDLE_WORD.
- First cycle after reset release: an=4'b1110, showing blank segments.
- Outputs an/seg/dp are registered and change only at a scan index step or a digit commit.
- Celsius latency from a `raw` change to the updated digit register: 11 cycles (input reg 1, IDLE detect 1, LATCH 1, SHIFT 8). The display reflects it on the next scan of each digit.
- Hex latency: 3 cycles.
- busy is high from the LATCH cycle through the COMMIT cycle inclusive (10 cycles Celsius, 2 hex).
- A mode change alone retriggers a conversion with the same latency.
- Reset asserted mid-conversion aborts it and returns to reset state in one cycle. No partial commit.

## Structure
- Package `temp_display_pkg` holds:
  - the FSM state encoding;
  - the digit codes, including DIG_BLANK and DIG_MINUS;
  - the 18-entry 7-segment pattern constant/function.
- Sub-module `bin2bcd_seq` implements the 8-bit iterative double-dabble with ports start, bin[7:0], done, bcd[11:0].
- Scan mux and digit-format logic stay in the top module.

## Test plan
All scenarios use REFRESH_DIV=4 and sw=0 unless stated otherwise.
- Reset, then raw=16'hFFFF held for 40 cycles:
  - busy stays 0.
  - an cycles 1110→1101→1011→0111 every 4 cycles.
  - seg stays 7'h7F and dp=1.
- raw=16'h0C80 (25.0 °C):
  - busy rises 3 cycles later and lasts 10 cycles.
  - Display reads blank, '2', '5'+dp, '0'.
- raw=16'hE480 (−55.0 °C): display reads '-', '5', '5'+dp, '0'. raw=16'h0198 (3.1875 °C): display reads blank, blank, '3'+dp, '1'.
- raw=16'h8000 (−256 °C): display reads '-', '-', '-', '-' with dp off.
- raw=16'h0C80, then sw=2'b01:
  - A new conversion starts; 3 cycles after the sw change the digits read '0','C','8','0', dp off.
  - sw=2'b11 gives the same result (sw[1] is ignored).
- Scenarios with changes or reset during a conversion:
  - raw changes 0C80→0D00 during SHIFT: the first commit shows 25.0, then a second conversion shows 26.0.
  - reset pulsed low during SHIFT: digits go BLANK and busy=0.

Source files
------------

// File: rtl/temp_display_pkg.sv
// rtl/temp_display_pkg.sv - shared types, digit codes and segment patterns for temp_display
package temp_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    localparam logic [4:0] DIG_BLANK = 5'd16;
    localparam logic [4:0] DIG_MINUS = 5'd17;

    // Active-low {g,f,e,d,c,b,a} for the 18 digit codes.
    function automatic logic [6:0] seg_pattern(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'd0:    pat = 7'h40;
            5'd1:    pat = 7'h79;
            5'd2:    pat = 7'h24;
            5'd3:    pat = 7'h30;
            5'd4:    pat = 7'h19;
            5'd5:    pat = 7'h12;
            5'd6:    pat = 7'h02;
            5'd7:    pat = 7'h78;
            5'd8:    pat = 7'h00;
            5'd9:    pat = 7'h10;
            5'd10:   pat = 7'h08;
            5'd11:   pat = 7'h03;
            5'd12:   pat = 7'h46;
            5'd13:   pat = 7'h21;
            5'd14:   pat = 7'h06;
            5'd15:   pat = 7'h0E;
            5'd17:   pat = 7'h3F;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 8-bit iterative double-dabble, one add-3/shift step per cycle
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [11:0] adj;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            bin_d = bin;
            bcd_d = 12'd0;
            cnt_d = 3'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, bin_d} = {adj[10:0], bin_q, 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_q <= 8'd0;
            bcd_q <= 12'd0;
            cnt_q <= 3'd0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // High during the final step; bcd holds the result from the next cycle on.
    assign done = run_q && (cnt_q == 3'd7);
    assign bcd  = bcd_q;

endmodule

// File: rtl/temp_display.sv
// rtl/temp_display.sv - ADT7420 result word to 4-digit multiplexed 7-segment display
module temp_display
    import temp_display_pkg::*;
#(
    parameter int          REFRESH_DIV = 50000,
    parameter logic [15:0] IDLE_WORD   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] raw,
    input  logic [1:0]  sw,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    state_t          state_q, state_d;
    logic [15:0]     raw_q, shown_raw_q, shown_raw_d, lat_raw_q, lat_raw_d;
    logic            mode_q, shown_mode_q, shown_mode_d, lat_mode_q, lat_mode_d;
    logic            neg_q, neg_d;
    logic [8:0]      whole_q, whole_d;
    logic [3:0]      tenths_q, tenths_d;
    logic [3:0][4:0] dig_q, dig_d;
    logic            dp_en_q, dp_en_d, busy_q, busy_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [12:0]     t_val, mag;
    logic [7:0]      frac_x10;
    logic            bcd_start, bcd_done;
    logic [11:0]     bcd;
    logic            unused_sw;

    assign unused_sw = sw[1];

    always_comb begin
        t_val     = raw_q[15:3];
        mag       = t_val[12] ? (~t_val + 13'd1) : t_val;
        frac_x10  = {4'd0, mag[3:0]} * 8'd10;
        bcd_start = (state_q == ST_LATCH) && !mode_q;
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (bcd_start),
        .bin   (mag[11:4]),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    always_comb begin
        state_d      = state_q;
        shown_raw_d  = shown_raw_q;
        shown_mode_d = shown_mode_q;
        lat_raw_d    = lat_raw_q;
        lat_mode_d   = lat_mode_q;
        neg_d        = neg_q;
        whole_d      = whole_q;
        tenths_d     = tenths_q;
        dig_d        = dig_q;
        dp_en_d      = dp_en_q;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (raw_q != IDLE_WORD && (raw_q != shown_raw_q || mode_q != shown_mode_q)) begin
                    state_d = ST_LATCH;
                    busy_d  = 1'b1;
                end
            end
            ST_LATCH: begin
                lat_raw_d  = raw_q;
                lat_mode_d = mode_q;
                neg_d      = t_val[12];
                whole_d    = mag[12:4];
                tenths_d   = frac_x10[7:4];
                state_d    = mode_q ? ST_COMMIT : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bcd_done) begin
                    state_d = ST_COMMIT;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                shown_raw_d  = lat_raw_q;
                shown_mode_d = lat_mode_q;
                if (lat_mode_q) begin
                    for (int k = 0; k < 4; k++) begin
                        dig_d[k] = {1'b0, lat_raw_q[k*4 +: 4]};
                    end
                    dp_en_d = 1'b0;
                end else if (whole_q[8] || (neg_q && whole_q >= 9'd100)) begin
                    dig_d   = {4{DIG_MINUS}};
                    dp_en_d = 1'b0;
                end else begin
                    dig_d[0] = {1'b0, tenths_q};
                    dig_d[1] = {1'b0, bcd[3:0]};
                    dig_d[2] = (bcd[11:4] == 8'd0) ? DIG_BLANK : {1'b0, bcd[7:4]};
                    dig_d[3] = neg_q ? DIG_MINUS :
                               ((bcd[11:8] == 4'd0) ? DIG_BLANK : {1'b0, bcd[11:8]});
                    dp_en_d  = 1'b1;
                end
            end
        endcase
    end

    // Outputs follow the current index/digits one cycle later.
    always_comb begin
        cnt_d = (cnt_q == 16'(REFRESH_DIV - 1)) ? 16'd0 : cnt_q + 16'd1;
        idx_d = (cnt_q == 16'(REFRESH_DIV - 1)) ? idx_q + 2'd1 : idx_q;
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_pattern(dig_q[idx_q]);
        dp_d  = ~(dp_en_q && (idx_q == 2'd1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            raw_q        <= IDLE_WORD;
            mode_q       <= 1'b0;
            shown_raw_q  <= IDLE_WORD;
            shown_mode_q <= 1'b0;
            lat_raw_q    <= 16'd0;
            lat_mode_q   <= 1'b0;
            neg_q        <= 1'b0;
            whole_q      <= 9'd0;
            tenths_q     <= 4'd0;
            dig_q        <= {4{DIG_BLANK}};
            dp_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= 16'd0;
            idx_q        <= 2'd0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            raw_q        <= raw;
            mode_q       <= sw[0];
            shown_raw_q  <= shown_raw_d;
            shown_mode_q <= shown_mode_d;
            lat_raw_q    <= lat_raw_d;
            lat_mode_q   <= lat_mode_d;
            neg_q        <= neg_d;
            whole_q      <= whole_d;
            tenths_q     <= tenths_d;
            dig_q        <= dig_d;
            dp_en_q      <= dp_en_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_temp_display.sv
// tb/tb_temp_display.sv - randomized self-checking bench for temp_display against a behavioural model
module tb_temp_display;

    localparam int          DIV   = 4;
    localparam logic [15:0] IDLE  = 16'hFFFF;
    localparam int          BLANK = 16;
    localparam int          MINUS = 17;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] raw;
    logic [1:0]  sw;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_seen = 0;

    // Model state: display timeline derived from the conversion rules.
    logic [15:0] m_raw_q, m_shown_raw, m_cap_raw;
    logic        m_mode_q, m_shown_mode, m_cap_mode;
    logic        m_busy, m_latch_next;
    int          m_left, m_cnt, m_idx;
    int          m_dig [4];
    logic        m_dpen;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;

    temp_display #(.REFRESH_DIV(DIV), .IDLE_WORD(IDLE)) dut (
        .clk   (clk),
        .reset (reset),
        .raw   (raw),
        .sw    (sw),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int code);
        logic [6:0] hi;
        case (code)
            0: hi = 7'h3F;  1: hi = 7'h06;  2: hi = 7'h5B;  3: hi = 7'h4F;
            4: hi = 7'h66;  5: hi = 7'h6D;  6: hi = 7'h7D;  7: hi = 7'h07;
            8: hi = 7'h7F;  9: hi = 7'h6F;  10: hi = 7'h77; 11: hi = 7'h7C;
            12: hi = 7'h39; 13: hi = 7'h5E; 14: hi = 7'h79; 15: hi = 7'h71;
            MINUS: hi = 7'h40;
            default: hi = 7'h00;
        endcase
        return ~hi;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic format(input logic [15:0] r, input logic hexm);
        int t, mag, ip, tenths;
        logic neg;
        if (hexm) begin
            for (int k = 0; k < 4; k++) m_dig[k] = int'(r[k*4 +: 4]);
            m_dpen = 1'b0;
            return;
        end
        t = int'(r[15:3]);
        if (t >= 4096) t = t - 8192;
        neg    = (t < 0);
        mag    = neg ? -t : t;
        ip     = mag / 16;
        tenths = ((mag % 16) * 10) / 16;
        if (ip > 255 || (neg && ip >= 100)) begin
            for (int k = 0; k < 4; k++) m_dig[k] = MINUS;
            m_dpen = 1'b0;
        end else begin
            m_dig[0] = tenths;
            m_dig[1] = ip % 10;
            m_dig[2] = (ip < 10) ? BLANK : (ip / 10) % 10;
            m_dig[3] = neg ? MINUS : ((ip < 100) ? BLANK : ip / 100);
            m_dpen   = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
            m_busy = 1'b0; m_latch_next = 1'b0; m_left = 0;
            m_cnt = 0; m_idx = 0; m_dpen = 1'b0;
            for (int k = 0; k < 4; k++) m_dig[k] = BLANK;
            m_shown_raw = IDLE; m_shown_mode = 1'b0;
            m_raw_q = IDLE; m_mode_q = 1'b0;
            return;
        end
        m_an  = 4'hF ^ (4'b0001 << m_idx);
        m_seg = pat(m_dig[m_idx]);
        m_dp  = !(m_dpen && m_idx == 1);
        m_cnt = m_cnt + 1;
        if (m_cnt == DIV) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
        end
        if (m_latch_next) begin
            m_cap_raw    = m_raw_q;
            m_cap_mode   = m_mode_q;
            m_left       = m_cap_mode ? 1 : 9;
            m_latch_next = 1'b0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                format(m_cap_raw, m_cap_mode);
                m_shown_raw  = m_cap_raw;
                m_shown_mode = m_cap_mode;
                m_busy       = 1'b0;
            end
        end else if (m_raw_q != IDLE && (m_raw_q != m_shown_raw || m_mode_q != m_shown_mode)) begin
            m_busy       = 1'b1;
            m_latch_next = 1'b1;
        end
        m_raw_q  = raw;
        m_mode_q = sw[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("an", int'(an), int'(m_an));
        check("seg", int'(seg), int'(m_seg));
        check("dp", int'(dp), int'(m_dp));
        check("busy", int'(busy), int'(m_busy));
        if (busy) busy_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pin(input string name, input int d3, input int d2, input int d1, input int d0,
                       input logic dpe);
        check({name, "_d3"}, m_dig[3], d3);
        check({name, "_d2"}, m_dig[2], d2);
        check({name, "_d1"}, m_dig[1], d1);
        check({name, "_d0"}, m_dig[0], d0);
        check({name, "_dp"}, int'(m_dpen), int'(dpe));
    endtask

    initial begin
        reset = 1'b0;
        raw   = IDLE;
        sw    = 2'b00;
        ticks(3);
        reset = 1'b1;
        busy_seen = 0;
        ticks(40);
        check("idle_busy_cycles", busy_seen, 0);

        raw = 16'h0C80; busy_seen = 0; ticks(24);
        check("c25_busy_cycles", busy_seen, 10);
        pin("c25", BLANK, 2, 5, 0, 1'b1);

        raw = 16'hE480; ticks(24); pin("m55", MINUS, 5, 5, 0, 1'b1);
        raw = 16'h0198; ticks(24); pin("c3_1", BLANK, BLANK, 3, 1, 1'b1);
        raw = 16'h8000; ticks(24); pin("m256", MINUS, MINUS, MINUS, MINUS, 1'b0);

        raw = 16'h0C80; ticks(24);
        sw = 2'b01; busy_seen = 0; ticks(24);
        check("hex_busy_cycles", busy_seen, 2);
        pin("hex", 0, 12, 8, 0, 1'b0);
        sw = 2'b11; busy_seen = 0; ticks(16);
        check("sw1_ignored_busy", busy_seen, 0);
        sw = 2'b00; ticks(24);

        raw = 16'h0198; ticks(24);
        raw = 16'h0C80; busy_seen = 0; ticks(5);
        raw = 16'h0D00; ticks(7);
        pin("first_commit", BLANK, 2, 5, 0, 1'b1);
        ticks(24);
        pin("second_commit", BLANK, 2, 6, 0, 1'b1);
        check("two_conv_busy", busy_seen, 20);

        raw = 16'hE480; ticks(5);
        reset = 1'b0; tick();
        pin("reset_mid", BLANK, BLANK, BLANK, BLANK, 1'b0);
        reset = 1'b1; ticks(30);

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 5))
                0: raw = IDLE;
                1: raw = {$urandom_range(0, 8191), 3'b000} ^ 16'h8000;
                default: raw = 16'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) sw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0; tick(); reset = 1'b1;
            end
            ticks($urandom_range(1, 14));
        end
        ticks(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
